alu_scheduler: RTL
==================

# alu_scheduler

Two-requester scheduler for the shared 32-bit ALU (inputs A, B, ALUOp; output C). It accepts operation requests over valid/ready handshakes and arbitrates round-robin between them. It drives the ALU operands from stable registers for one full cycle, captures C, and returns the result to the owning requester. It sits between the ALU and its clients (datapath control and a debug/test port) so the ALU instance itself stays purely combinational.

## Interface
- W, 32, operand/result width
- CW, 16, width of completed-operation counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_ready / req1_ready  out  1  scheduler accepts requester N this cycle
- req0_a / req1_a  in  W  operand A
- req0_b / req1_b  in  W  operand B
- req0_op / req1_op  in  3  ALUOp, passed through unmodified
- resp0_valid / resp1_valid  out  1  result for requester N available
- resp0_ready / resp1_ready  in  1  requester N consumes result
- resp0_c / resp1_c  out  W  result register for requester N
- alu_a, alu_b  out  W  registered ALU operands
- alu_op  out  3  registered ALUOp
- alu_c  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
- op_count  out  CW  completed operations, wraps modulo 2^CW

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Registers: owner (1 bit), last_grant (1 bit, reset value 1 so req0 wins the first contention), operand/op registers, one result register per requester, op_count.
- IDLE grant:
  - only reqN_valid set → grant N
  - both set → grant the one not equal to last_grant
  - neither set → no grant
- reqN_ready = (state==IDLE) && granted N. It is combinational from valid, so requesters must not make valid depend on ready.
- Handshake (reqN_valid && reqN_ready):
  - latch a, b, op into alu_a/alu_b/alu_op
  - owner := N
  - → EXEC
- EXEC (exactly 1 cycle): alu_c is sampled at the end of the cycle into respN_c of owner → RESP. The other requester's result register is untouched.
- RESP:
  - resp[owner]_valid = 1
  - on resp[owner]_ready: op_count += 1, last_grant := owner → IDLE
  - the held response blocks both requesters (no new accept until IDLE)
- respN_c holds its last captured value indefinitely. It is meaningful only while respN_valid is high.
- alu_a/alu_b/alu_op hold their last values between operations.
- Arithmetic is performed solely by the external ALU. The scheduler does no width conversion.
- Reset outputs: all ready/valid 0, resp0_c/resp1_c 0, alu_a/alu_b 0, alu_op 0, op_count 0.

## Timing
- Handshake in cycle T → EXEC in T+1 (ALU inputs stable all of T+1) → resp valid from T+2.
- With respN_ready already high at T+2: back in IDLE at T+3, next accept possible at T+3. Minimum 3 cycles per operation.
- No overlap between operations.
- op_count updates at the edge ending the response-handshake cycle. It wraps 0xFFFF → 0x0000.
- Back-pressure: resp valid and data are held unchanged for any number of cycles while ready is low.
- respN_ready asserted while respN_valid is low is ignored.
- reqN_valid dropping in IDLE before a handshake withdraws the request. There is no sticky grant.
- Reset in any state, including EXEC or RESP:
  - the pending operation is dropped and never responded to
  - FSM → IDLE, last_grant → 1, all outputs return to their reset values on that edge

## Test plan
Bench pairs the scheduler with the team ALU (encoding 0=add, 1=sub, 5=sra).
- Reset: hold reset 2 cycles with both req valid high → both ready 0, both resp valid 0, alu_a/alu_b/alu_op 0, op_count 0.
- Single add: req0 a=3, b=4, op=0 at T → alu_a=3, alu_b=4 during T+1; resp0_valid at T+2 with resp0_c=0x00000007; op_count=1 after the response handshake.
- Shift: req1 a=0x8AC92839, b=5, op=5 → resp1_c=0xFC564941; resp0_c keeps its prior value.
- Contention: both valid continuously after reset, all resp ready high → accepts alternate req0, req1, req0, req1, one every 3 cycles; op_count=4 after 12 cycles.
- Back-pressure: resp0_ready low 10 cycles after a req0 sub a=10, b=3 → resp0_valid and resp0_c=7 stable for all 10 cycles; req1_ready stays 0 throughout; op_count unchanged until resp0_ready rises.
- Reset mid-op: assert reset during EXEC → no response ever appears; all outputs at reset values on the next edge; the next contention grants req0 first.

Source files
------------

// File: rtl/alu_scheduler.sv
// Round-robin scheduler that time-shares one combinational ALU between two
// valid/ready requesters: accept, drive operands for one cycle, capture, respond.
module alu_scheduler #(
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   input  logic [2:0]    req0_op,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   input  logic [2:0]    req1_op,
   output logic          resp0_valid,
   input  logic          resp0_ready,
   output logic [W-1:0]  resp0_c,
   output logic          resp1_valid,
   input  logic          resp1_ready,
   output logic [W-1:0]  resp1_c,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [2:0]    alu_op,
   input  logic [W-1:0]  alu_c,
   output logic [CW-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic [W-1:0]  resp0_c_q, resp0_c_d;
   logic [W-1:0]  resp1_c_q, resp1_c_d;
   logic [CW-1:0] op_count_q, op_count_d;

   logic grant0, grant1, resp_hs;

   // Under contention the requester that did not win last time is favoured.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
   end

   assign req0_ready  = !reset && (state_q == IDLE) && grant0;
   assign req1_ready  = !reset && (state_q == IDLE) && grant1;
   assign resp0_valid = (state_q == RESP) && !owner_q;
   assign resp1_valid = (state_q == RESP) && owner_q;
   assign resp_hs     = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

   always_comb begin
      // NOTE: every next-state signal defaults to its register first, so no path leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      resp0_c_d    = resp0_c_q;
      resp1_c_d    = resp1_c_q;
      op_count_d   = op_count_q;
      unique case (state_q)
         IDLE: begin
            if (req0_ready) begin
               alu_a_d  = req0_a;
               alu_b_d  = req0_b;
               alu_op_d = req0_op;
               owner_d  = 1'b0;
               state_d  = EXEC;
            end else if (req1_ready) begin
               alu_a_d  = req1_a;
               alu_b_d  = req1_b;
               alu_op_d = req1_op;
               owner_d  = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // Operands have been stable for this whole cycle, so alu_c is settled.
            if (owner_q) resp1_c_d = alu_c;
            else         resp0_c_d = alu_c;
            state_d = RESP;
         end
         RESP: begin
            if (resp_hs) begin
               op_count_d   = op_count_q + CW'(1);
               last_grant_d = owner_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         resp0_c_q    <= '0;
         resp1_c_q    <= '0;
         op_count_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         resp0_c_q    <= resp0_c_d;
         resp1_c_q    <= resp1_c_d;
         op_count_q   <= op_count_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign resp0_c  = resp0_c_q;
   assign resp1_c  = resp1_c_q;
   assign op_count = op_count_q;

endmodule
